multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_if.sv | 58 +++++
 rtl/multicycle_control.sv | 255 +++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control-unit signal bundle between the multicycle controller and the datapath/memory side.
// The master side is the controller; the slave side supplies the opcode and the memory ready.
interface multicycle_control_if;
    logic [6:0]  opcode_i;
    logic        mem_ready_i;
    logic        mem_read_o;
    logic        mem_write_o;
    logic        ir_write_o;
    logic        pc_write_o;
    logic [1:0]  pc_src_o;
    logic        branch_o;
    logic        reg_write_o;
    logic [1:0]  mem_to_reg_o;
    logic [1:0]  alu_src_a_o;
    logic        alu_src_b_o;
    logic [2:0]  alu_op_o;
    logic [3:0]  state_o;
    logic        halted_o;
    logic [31:0] instret_o;

    modport master (
        input  opcode_i,
        input  mem_ready_i,
        output mem_read_o,
        output mem_write_o,
        output ir_write_o,
        output pc_write_o,
        output pc_src_o,
        output branch_o,
        output reg_write_o,
        output mem_to_reg_o,
        output alu_src_a_o,
        output alu_src_b_o,
        output alu_op_o,
        output state_o,
        output halted_o,
        output instret_o
    );

    modport slave (
        output opcode_i,
        output mem_ready_i,
        input  mem_read_o,
        input  mem_write_o,
        input  ir_write_o,
        input  pc_write_o,
        input  pc_src_o,
        input  branch_o,
        input  reg_write_o,
        input  mem_to_reg_o,
        input  alu_src_a_o,
        input  alu_src_b_o,
        input  alu_op_o,
        input  state_o,
        input  halted_o,
        input  instret_o
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore-style control FSM for a multicycle RV32I datapath.
// Outputs decode from the state register and the op class latched in DECODE.
module multicycle_control (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXEC   = 4'd2,
        ADDR   = 4'd3,
        MEM_RD = 4'd4,
        MEM_WR = 4'd5,
        WB_ALU = 4'd6,
        WB_MEM = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        TRAP   = 4'd15
    } state_t;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    // Store and JAL share class 101; the path taken in DECODE separates them.
    localparam logic [2:0] CL_R      = 3'd0;
    localparam logic [2:0] CL_I      = 3'd1;
    localparam logic [2:0] CL_LUI    = 3'd2;
    localparam logic [2:0] CL_LOAD   = 3'd3;
    localparam logic [2:0] CL_BR     = 3'd4;
    localparam logic [2:0] CL_ST_JAL = 3'd5;
    localparam logic [2:0] CL_JALR   = 3'd6;
    localparam logic [2:0] CL_AUIPC  = 3'd7;

    state_t      state;
    state_t      dec_next;
    logic [2:0]  op_class;
    logic [2:0]  dec_class;
    logic [31:0] instret_q;
    logic        halted_q;

    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        branch;
    logic        reg_write;
    logic [1:0]  mem_to_reg;
    logic [1:0]  alu_src_a;
    logic        alu_src_b;

    // Opcode classification; only consumed by the DECODE transition.
    always_comb begin
        dec_class = CL_R;
        dec_next  = TRAP;
        unique case (1'b1)
            (bus.opcode_i == OPC_R): begin
                dec_class = CL_R;
                dec_next  = EXEC;
            end
            (bus.opcode_i == OPC_I): begin
                dec_class = CL_I;
                dec_next  = EXEC;
            end
            (bus.opcode_i == OPC_LUI): begin
                dec_class = CL_LUI;
                dec_next  = EXEC;
            end
            (bus.opcode_i == OPC_AUIPC): begin
                dec_class = CL_AUIPC;
                dec_next  = EXEC;
            end
            (bus.opcode_i == OPC_LOAD): begin
                dec_class = CL_LOAD;
                dec_next  = ADDR;
            end
            (bus.opcode_i == OPC_STORE): begin
                dec_class = CL_ST_JAL;
                dec_next  = ADDR;
            end
            (bus.opcode_i == OPC_BR): begin
                dec_class = CL_BR;
                dec_next  = BRANCH;
            end
            (bus.opcode_i == OPC_JAL): begin
                dec_class = CL_ST_JAL;
                dec_next  = JUMP;
            end
            (bus.opcode_i == OPC_JALR): begin
                dec_class = CL_JALR;
                dec_next  = JUMP;
            end
            default: begin
                dec_class = CL_R;
                dec_next  = TRAP;
            end
        endcase
    end

    // State, op class, retire counter and trap flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= FETCH;
            op_class  <= CL_R;
            instret_q <= 32'd0;
            halted_q  <= 1'b0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (bus.mem_ready_i) state <= DECODE;
                end
                DECODE: begin
                    op_class <= dec_class;
                    state    <= dec_next;
                    if (dec_next == TRAP) halted_q <= 1'b1;
                end
                EXEC: begin
                    state <= WB_ALU;
                end
                WB_ALU: begin
                    state     <= FETCH;
                    instret_q <= instret_q + 32'd1;
                end
                ADDR: begin
                    state <= (op_class == CL_LOAD) ? MEM_RD : MEM_WR;
                end
                MEM_RD: begin
                    if (bus.mem_ready_i) state <= WB_MEM;
                end
                WB_MEM: begin
                    state     <= FETCH;
                    instret_q <= instret_q + 32'd1;
                end
                MEM_WR: begin
                    if (bus.mem_ready_i) begin
                        state     <= FETCH;
                        instret_q <= instret_q + 32'd1;
                    end
                end
                BRANCH: begin
                    state     <= FETCH;
                    instret_q <= instret_q + 32'd1;
                end
                JUMP: begin
                    state     <= FETCH;
                    instret_q <= instret_q + 32'd1;
                end
                TRAP: begin
                    state    <= TRAP;
                    halted_q <= 1'b1;
                end
                default: begin
                    state    <= TRAP;
                    halted_q <= 1'b1;
                end
            endcase
        end
    end

    // Control decode from state and latched class; only FETCH looks at mem_ready.
    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        branch     = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 1'b0;
        unique case (state)
            FETCH: begin
                mem_read = 1'b1;
                ir_write = bus.mem_ready_i;
                pc_write = bus.mem_ready_i;
                pc_src   = 2'b00;
            end
            EXEC: begin
                alu_src_b = (op_class != CL_R);
                if (op_class == CL_AUIPC)
                    alu_src_a = 2'b01;
                else if (op_class == CL_LUI)
                    alu_src_a = 2'b10;
                else
                    alu_src_a = 2'b00;
            end
            WB_ALU: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b00;
            end
            ADDR: begin
                alu_src_a = 2'b00;
                alu_src_b = 1'b1;
            end
            MEM_RD: begin
                mem_read = 1'b1;
            end
            WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
            end
            MEM_WR: begin
                mem_write = 1'b1;
            end
            BRANCH: begin
                alu_src_b = 1'b0;
                branch    = 1'b1;
                pc_write  = 1'b1;
                pc_src    = 2'b01;
            end
            JUMP: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b10;
                pc_write   = 1'b1;
                pc_src     = 2'b10;
                alu_src_a  = (op_class == CL_ST_JAL) ? 2'b01 : 2'b00;
                alu_src_b  = 1'b1;
            end
            default: begin
                mem_read = 1'b0;
            end
        endcase
    end

    // A read and a write request must never overlap.
    a_rw_exclusive: assert property (
        @(posedge clk) disable iff (!reset) !(mem_read && mem_write)
    );

    assign bus.mem_read_o   = mem_read;
    assign bus.mem_write_o  = mem_write;
    assign bus.ir_write_o   = ir_write;
    assign bus.pc_write_o   = pc_write;
    assign bus.pc_src_o     = pc_src;
    assign bus.branch_o     = branch;
    assign bus.reg_write_o  = reg_write;
    assign bus.mem_to_reg_o = mem_to_reg;
    assign bus.alu_src_a_o  = alu_src_a;
    assign bus.alu_src_b_o  = alu_src_b;
    assign bus.alu_op_o     = op_class;
    assign bus.state_o      = state;
    assign bus.halted_o     = halted_q;
    assign bus.instret_o    = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control against an instruction-level model.
// The model lists the expected state walk and per-instruction pulse counts.
module tb_multicycle_control;

    logic clk = 1'b0;
    logic reset;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_instret;
    int          q_st[$];
    bit          q_rdy[$];
    logic [6:0]  legal_ops[9] = '{OPC_R, OPC_I, OPC_LUI, OPC_LOAD, OPC_BR,
                                  OPC_STORE, OPC_JAL, OPC_JALR, OPC_AUIPC};

    function automatic logic [2:0] class_of(input logic [6:0] op);
        case (op)
            OPC_R:     return 3'd0;
            OPC_I:     return 3'd1;
            OPC_LUI:   return 3'd2;
            OPC_LOAD:  return 3'd3;
            OPC_BR:    return 3'd4;
            OPC_STORE: return 3'd5;
            OPC_JAL:   return 3'd5;
            OPC_JALR:  return 3'd6;
            OPC_AUIPC: return 3'd7;
            default:   return 3'd0;
        endcase
    endfunction

    task automatic push(input int st, input bit rdy);
        q_st.push_back(st);
        q_rdy.push_back(rdy);
    endtask

    // Expected state walk of one instruction given its memory wait counts.
    task automatic build(input logic [6:0] op, input int fw, input int rw, input int ww);
        q_st.delete();
        q_rdy.delete();
        repeat (fw) push(0, 1'b0);
        push(0, 1'b1);
        push(1, 1'($urandom_range(1, 0)));
        if (op == OPC_R || op == OPC_I || op == OPC_LUI || op == OPC_AUIPC) begin
            push(2, 1'($urandom_range(1, 0)));
            push(6, 1'($urandom_range(1, 0)));
        end else if (op == OPC_LOAD) begin
            push(3, 1'($urandom_range(1, 0)));
            repeat (rw) push(4, 1'b0);
            push(4, 1'b1);
            push(7, 1'($urandom_range(1, 0)));
        end else if (op == OPC_STORE) begin
            push(3, 1'($urandom_range(1, 0)));
            repeat (ww) push(5, 1'b0);
            push(5, 1'b1);
        end else if (op == OPC_BR) begin
            push(8, 1'($urandom_range(1, 0)));
        end else begin
            push(9, 1'($urandom_range(1, 0)));
        end
    endtask

    task automatic run_instr(input logic [6:0] op, input int fw, input int rw, input int ww);
        bit         is_ld, is_st, is_br, is_jmp;
        int         c_mr, c_mw, c_rw, c_ir, c_pw, c_br;
        int         e_mr, e_mw, e_rw, e_pw;
        logic [1:0] e_m2r, e_a;
        is_ld  = (op == OPC_LOAD);
        is_st  = (op == OPC_STORE);
        is_br  = (op == OPC_BR);
        is_jmp = (op == OPC_JAL || op == OPC_JALR);
        e_rw   = (is_st || is_br) ? 0 : 1;
        e_mw   = is_st ? ww + 1 : 0;
        e_mr   = fw + 1 + (is_ld ? rw + 1 : 0);
        e_pw   = 1 + ((is_br || is_jmp) ? 1 : 0);
        e_m2r  = is_ld ? 2'd1 : (is_jmp ? 2'd2 : 2'd0);
        c_mr = 0; c_mw = 0; c_rw = 0; c_ir = 0; c_pw = 0; c_br = 0;
        build(op, fw, rw, ww);
        for (int i = 0; i < q_st.size(); i++) begin
            @(negedge clk);
            bus.opcode_i    = op;
            bus.mem_ready_i = q_rdy[i];
            #1;
            n_assert++;
            if (bus.state_o !== 4'(q_st[i])) begin
                n_fail++;
                $display("FAIL state op=%b cyc=%0d: got %0d want %0d", op, i, bus.state_o, q_st[i]);
            end
            n_assert++;
            if (bus.mem_read_o === 1'b1 && bus.mem_write_o === 1'b1) begin
                n_fail++;
                $display("FAIL rw_excl op=%b cyc=%0d: got rd=1 wr=1 want not both", op, i);
            end
            c_mr += int'(bus.mem_read_o === 1'b1);
            c_mw += int'(bus.mem_write_o === 1'b1);
            c_rw += int'(bus.reg_write_o === 1'b1);
            c_ir += int'(bus.ir_write_o === 1'b1);
            c_pw += int'(bus.pc_write_o === 1'b1);
            c_br += int'(bus.branch_o === 1'b1);
            if (bus.reg_write_o === 1'b1) begin
                n_assert++;
                if (bus.mem_to_reg_o !== e_m2r) begin
                    n_fail++;
                    $display("FAIL mem_to_reg op=%b: got %0d want %0d", op, bus.mem_to_reg_o, e_m2r);
                end
            end
            if (q_st[i] == 2) begin
                e_a = (op == OPC_AUIPC) ? 2'd1 : ((op == OPC_LUI) ? 2'd2 : 2'd0);
                n_assert++;
                if (bus.alu_src_a_o !== e_a || bus.alu_src_b_o !== (op != OPC_R)) begin
                    n_fail++;
                    $display("FAIL exec_src op=%b: got a=%0d b=%0d want a=%0d b=%0d",
                             op, bus.alu_src_a_o, bus.alu_src_b_o, e_a, op != OPC_R);
                end
            end
            if (q_st[i] == 3) begin
                n_assert++;
                if (bus.alu_src_a_o !== 2'd0 || bus.alu_src_b_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL addr_src: got a=%0d b=%0d want a=0 b=1",
                             bus.alu_src_a_o, bus.alu_src_b_o);
                end
            end
            if (q_st[i] == 8) begin
                n_assert++;
                if (bus.pc_src_o !== 2'd1 || bus.alu_src_b_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL branch_sel: got pc_src=%0d b=%0d want pc_src=1 b=0",
                             bus.pc_src_o, bus.alu_src_b_o);
                end
            end
            if (q_st[i] == 9) begin
                e_a = (op == OPC_JAL) ? 2'd1 : 2'd0;
                n_assert++;
                if (bus.pc_src_o !== 2'd2 || bus.alu_src_a_o !== e_a || bus.alu_src_b_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL jump_sel op=%b: got pc_src=%0d a=%0d b=%0d want 2 %0d 1",
                             op, bus.pc_src_o, bus.alu_src_a_o, bus.alu_src_b_o, e_a);
                end
            end
        end
        @(posedge clk);
        #1;
        exp_instret = exp_instret + 32'd1;
        n_assert++;
        if (bus.state_o !== 4'd0) begin
            n_fail++;
            $display("FAIL end_state op=%b: got %0d want 0", op, bus.state_o);
        end
        n_assert++;
        if (bus.instret_o !== exp_instret) begin
            n_fail++;
            $display("FAIL instret op=%b: got %h want %h", op, bus.instret_o, exp_instret);
        end
        n_assert++;
        if (bus.alu_op_o !== class_of(op)) begin
            n_fail++;
            $display("FAIL alu_op op=%b: got %0d want %0d", op, bus.alu_op_o, class_of(op));
        end
        n_assert++;
        if (c_mr != e_mr || c_mw != e_mw || c_rw != e_rw || c_ir != 1 || c_pw != e_pw
            || c_br != int'(is_br)) begin
            n_fail++;
            $display("FAIL pulses op=%b: got rd=%0d wr=%0d rw=%0d ir=%0d pw=%0d br=%0d want %0d %0d %0d 1 %0d %0d",
                     op, c_mr, c_mw, c_rw, c_ir, c_pw, c_br, e_mr, e_mw, e_rw, e_pw, int'(is_br));
        end
    endtask

    task automatic test_reset;
        reset           = 1'b0;
        bus.opcode_i    = 7'd0;
        bus.mem_ready_i = 1'b0;
        exp_instret     = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        n_assert++;
        if (bus.state_o !== 4'd0 || bus.mem_read_o !== 1'b1 || bus.mem_write_o !== 1'b0
            || bus.ir_write_o !== 1'b0 || bus.pc_write_o !== 1'b0 || bus.reg_write_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got st=%0d rd=%b wr=%b ir=%b pw=%b rw=%b want 0 1 0 0 0 0",
                     bus.state_o, bus.mem_read_o, bus.mem_write_o, bus.ir_write_o,
                     bus.pc_write_o, bus.reg_write_o);
        end
        n_assert++;
        if (bus.instret_o !== 32'd0 || bus.halted_o !== 1'b0 || bus.alu_op_o !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_regs: got instret=%h halted=%b alu_op=%0d want 0 0 0",
                     bus.instret_o, bus.halted_o, bus.alu_op_o);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_r_type;
        run_instr(OPC_R, 0, 0, 0);
    endtask

    task automatic test_load_wait;
        run_instr(OPC_LOAD, 0, 3, 0);
    endtask

    task automatic test_store;
        run_instr(OPC_STORE, 1, 0, 2);
    endtask

    task automatic test_random;
        for (int k = 0; k < 40; k++) begin
            run_instr(legal_ops[$urandom_range(8, 0)], int'($urandom_range(2, 0)),
                      int'($urandom_range(3, 0)), int'($urandom_range(3, 0)));
        end
    endtask

    task automatic test_wrap;
        @(negedge clk);
        bus.mem_ready_i = 1'b0;
        force dut.instret_q = 32'hFFFF_FFFE;
        #1;
        release dut.instret_q;
        exp_instret = 32'hFFFF_FFFE;
        run_instr(OPC_BR, 0, 0, 0);
        run_instr(OPC_JAL, 0, 0, 0);
        n_assert++;
        if (bus.instret_o !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL wrap: got %h want 00000000", bus.instret_o);
        end
    endtask

    task automatic test_trap;
        @(negedge clk);
        bus.opcode_i    = 7'b1111111;
        bus.mem_ready_i = 1'b1;
        @(negedge clk);
        bus.mem_ready_i = 1'b0;
        #1;
        n_assert++;
        if (bus.state_o !== 4'd1) begin
            n_fail++;
            $display("FAIL trap_decode: got %0d want 1", bus.state_o);
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            bus.mem_ready_i = 1'($urandom_range(1, 0));
            bus.opcode_i    = legal_ops[$urandom_range(8, 0)];
            #1;
            n_assert++;
            if (bus.state_o !== 4'd15 || bus.halted_o !== 1'b1) begin
                n_fail++;
                $display("FAIL trap_hold cyc=%0d: got st=%0d halted=%b want 15 1",
                         k, bus.state_o, bus.halted_o);
            end
            n_assert++;
            if (bus.mem_read_o !== 1'b0 || bus.mem_write_o !== 1'b0 || bus.ir_write_o !== 1'b0
                || bus.pc_write_o !== 1'b0 || bus.reg_write_o !== 1'b0) begin
                n_fail++;
                $display("FAIL trap_quiet cyc=%0d: got rd=%b wr=%b ir=%b pw=%b rw=%b want all 0",
                         k, bus.mem_read_o, bus.mem_write_o, bus.ir_write_o,
                         bus.pc_write_o, bus.reg_write_o);
            end
            n_assert++;
            if (bus.instret_o !== exp_instret) begin
                n_fail++;
                $display("FAIL trap_instret: got %h want %h", bus.instret_o, exp_instret);
            end
        end
        @(negedge clk);
        bus.mem_ready_i = 1'b0;
        reset           = 1'b0;
        exp_instret     = 32'd0;
        #1;
        n_assert++;
        if (bus.state_o !== 4'd0 || bus.halted_o !== 1'b0 || bus.instret_o !== 32'd0) begin
            n_fail++;
            $display("FAIL trap_reset: got st=%0d halted=%b instret=%h want 0 0 0",
                     bus.state_o, bus.halted_o, bus.instret_o);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset_mid_store;
        @(negedge clk);
        bus.opcode_i    = OPC_STORE;
        bus.mem_ready_i = 1'b1;
        @(negedge clk);
        bus.mem_ready_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_assert++;
        if (bus.state_o !== 4'd5 || bus.mem_write_o !== 1'b1) begin
            n_fail++;
            $display("FAIL memwr_entry: got st=%0d wr=%b want 5 1", bus.state_o, bus.mem_write_o);
        end
        #1;
        reset = 1'b0;
        #1;
        exp_instret = 32'd0;
        n_assert++;
        if (bus.mem_write_o !== 1'b0 || bus.state_o !== 4'd0 || bus.mem_read_o !== 1'b1
            || bus.reg_write_o !== 1'b0 || bus.instret_o !== 32'd0) begin
            n_fail++;
            $display("FAIL async_reset: got wr=%b st=%0d rd=%b rw=%b instret=%h want 0 0 1 0 0",
                     bus.mem_write_o, bus.state_o, bus.mem_read_o, bus.reg_write_o, bus.instret_o);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_assert++;
        if (bus.state_o !== 4'd0 || bus.mem_read_o !== 1'b1 || bus.mem_write_o !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: got st=%0d rd=%b wr=%b want 0 1 0",
                     bus.state_o, bus.mem_read_o, bus.mem_write_o);
        end
        run_instr(OPC_STORE, 0, 0, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_r_type();
        test_load_wait();
        test_store();
        test_random();
        test_wrap();
        test_trap();
        test_reset_mid_store();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
